// File: rtl/intr_ctrl.sv
// Eight-line priority interrupt controller: edge-detects requests into a pending
// register and hands out one registered grant at a time through an IDLE/ASSERT/DONE handshake.
module intr_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    output logic       irq,
    output logic [7:0] h,
    output logic [2:0] vec,
    output logic       idle
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] req_q;
    logic [7:0] pending;
    logic [7:0] pending_next;
    logic [7:0] rise;
    logic [7:0] avail;
    logic [7:0] clr;
    logic [7:0] h_next;
    logic [2:0] sel;
    logic [2:0] vec_next;
    logic       irq_next;
    logic       idle_next;

    assign rise  = req & ~req_q;
    assign avail = pending & ~mask;

    // Ascending scan so the highest-index unmasked pending bit is the last to win.
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (avail[i]) begin
                sel = 3'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        vec_next   = vec;
        irq_next   = irq;
        h_next     = h;
        clr        = 8'h00;
        case (state)
            IDLE: begin
                if (|avail) begin
                    state_next = ASSERT;
                    vec_next   = sel;
                    irq_next   = 1'b1;
                    h_next     = 8'h01 << sel;
                end else begin
                    irq_next = 1'b0;
                    h_next   = 8'h00;
                end
            end
            ASSERT: begin
                if (ack) begin
                    clr        = 8'h01 << vec;
                    state_next = DONE;
                    irq_next   = 1'b0;
                    h_next     = 8'h00;
                end
            end
            DONE: begin
                state_next = IDLE;
                irq_next   = 1'b0;
                h_next     = 8'h00;
            end
            default: begin
                state_next = IDLE;
                irq_next   = 1'b0;
                h_next     = 8'h00;
            end
        endcase
        // A rise on the bit being cleared wins, so a fresh request is never lost.
        pending_next = (pending & ~clr) | rise;
        idle_next    = (state_next == IDLE) && ((pending_next & ~mask) == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 8'h00;
            pending <= 8'h00;
            state   <= IDLE;
            irq     <= 1'b0;
            h       <= 8'h00;
            vec     <= 3'd0;
            idle    <= 1'b1;
        end else begin
            req_q   <= req;
            pending <= pending_next;
            state   <= state_next;
            irq     <= irq_next;
            h       <= h_next;
            vec     <= vec_next;
            idle    <= idle_next;
        end
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req, input, 8 bits: raw request lines; req[7] highest priority, req[0] lowest.
REQ-004 SHALL have port mask, input, 8 bits: mask[n]=1 blocks pending[n] from selection only; the pending bit is not cleared.
REQ-005 SHALL have port ack, input, 1 bit: consumer acknowledge of the current grant.
REQ-006 SHALL have port irq, output, 1 bit: registered request-to-service flag.
REQ-007 SHALL have port h, output, 8 bits: registered one-hot grant; equals one-hot of vec while irq=1, else 0.
REQ-008 SHALL have port vec, output, 3 bits: registered binary index of the granted line.
REQ-009 SHALL have port idle, output, 1 bit: registered; 1 when state=IDLE and (pending & ~mask)=0.

Function
REQ-010 SHALL register req into req_q every cycle; rise[n] = req[n] & ~req_q[n].
REQ-011 SHALL hold an 8-bit pending register: pending_next = (pending & ~clr) | rise.
REQ-011a clr = one-hot(vec) in the cycle ack is accepted, else 0.
REQ-011b A rise on the bit being cleared in the same cycle leaves that bit set.
REQ-012 SHALL select the highest-index set bit of (pending & ~mask); only a single bit ever wins.
REQ-013 SHALL implement a 3-state FSM: IDLE, ASSERT, DONE.
REQ-014 IDLE: if (pending & ~mask)!=0, SHALL go to ASSERT at the next edge, loading vec=selected index, irq=1, h=one-hot(vec); else remain in IDLE with irq=0, h=0.
REQ-015 ASSERT: irq, vec and h SHALL hold stable regardless of new rises or mask changes.
REQ-015a On ack=1, SHALL clear pending[vec] and go to DONE with irq=0, h=0 at the next edge.
REQ-016 DONE: SHALL return to IDLE after exactly one cycle; irq=0 throughout.
REQ-016a Back-to-back grants are separated by at least 2 cycles of irq=0.
REQ-017 ack SHALL be ignored in IDLE and DONE.
REQ-018 Latency: req first sampled high at edge N -> pending set after edge N -> irq=1 after edge N+1, if the FSM was in IDLE and the bit is unmasked and highest.
REQ-019 A level held high SHALL produce exactly one pending event; re-request requires req low for at least one sampled cycle.
REQ-020 A rise on an already-set pending bit SHALL be absorbed; there is no counting.
REQ-021 vec SHALL retain its last value while irq=0; only h and irq are cleared.

Reset
REQ-022 With rst=1 at an edge, SHALL set:
REQ-022a pending=0, req_q=0, state=IDLE, irq=0, h=0, vec=0, idle=1.
REQ-023 Reset SHALL override all activity, including mid-ASSERT; the outstanding grant is dropped without requiring ack.
REQ-024 Because req_q resets to 0, a req line high when rst deasserts SHALL register as one rise on the first non-reset edge.

Verification
REQ-025 Single request: req=8'h04 held from edge N -> irq=1, vec=2, h=8'h04 after edge N+1; ack=1 one cycle -> irq=0, pending[2]=0; idle=1 two cycles later.
REQ-026 Priority: req=8'h81 rise same cycle -> grant vec=7, h=8'h80; after ack and DONE -> grant vec=0, h=8'h01, with 2 cycles of irq=0 between grants.
REQ-027 Mask: mask=8'h80, req=8'h81 -> grant vec=0; clear mask after ack -> vec=7 granted next; masked pending[7] survived.
REQ-028 Simultaneous clear and rise: in ASSERT with vec=3, pulse req[3] low then high so the rise coincides with ack -> pending[3] stays 1; re-grant of vec=3 after DONE.
REQ-029 Reset mid-operation: rst=1 during ASSERT (vec=5) -> next edge irq=0, h=0, vec=0, pending=0; req[5] still high -> one new grant of vec=5 after release.
REQ-030 Ack outside ASSERT: ack=1 in IDLE with pending=0 and in DONE -> no state or pending change.
